// File: rtl/led_effect_pkg.sv
// Shared definitions for the LED effect controller.
// Holds effect codes, start patterns, direction and a counter-width helper.
package led_effect_pkg;

  typedef enum logic [2:0] {
    EFF_OFF       = 3'd0,
    EFF_RUN_RIGHT = 3'd1,
    EFF_RUN_LEFT  = 3'd2,
    EFF_FILL      = 3'd3,
    EFF_PING_PONG = 3'd4,
    EFF_BLINK     = 3'd5,
    EFF_ALTERNATE = 3'd6,
    EFF_RESERVED  = 3'd7
  } effect_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  localparam logic [7:0] INIT_OFF       = 8'h00;
  localparam logic [7:0] INIT_RUN_RIGHT = 8'h80;
  localparam logic [7:0] INIT_RUN_LEFT  = 8'h01;
  localparam logic [7:0] INIT_FILL      = 8'h80;
  localparam logic [7:0] INIT_PING_PONG = 8'h80;
  localparam logic [7:0] INIT_BLINK     = 8'hFF;
  localparam logic [7:0] INIT_ALTERNATE = 8'hAA;

  function automatic logic [7:0] init_pattern(input logic [2:0] code);
    logic [7:0] pattern;
    case (code)
      EFF_RUN_RIGHT: pattern = INIT_RUN_RIGHT;
      EFF_RUN_LEFT:  pattern = INIT_RUN_LEFT;
      EFF_FILL:      pattern = INIT_FILL;
      EFF_PING_PONG: pattern = INIT_PING_PONG;
      EFF_BLINK:     pattern = INIT_BLINK;
      EFF_ALTERNATE: pattern = INIT_ALTERNATE;
      default:       pattern = INIT_OFF;
    endcase
    return pattern;
  endfunction

  // Never returns less than 1 so a divide-by-one counter still has a bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/led_effect_ctrl_tick_gen.sv
// Step strobe generator: counts CLK_DIV cycles while enabled.
// The clear input restarts the step period when a new effect is loaded.
module tick_gen
  import led_effect_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/led_effect_ctrl.sv
// LED effect controller: synchronised switch inputs select one of eight
// effects, advanced one step per tick from the tick_gen divider.
module led_effect_ctrl
  import led_effect_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic [7:0] led,
  output logic       tick,
  output logic [2:0] mode
);

  logic [3:0] sw_meta;
  logic [3:0] sw_s;
  logic       mode_change;
  logic       step_raw;
  dir_e       dir;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  assign mode_change = (sw_s[2:0] != mode);

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sw_s[3]),
    .clr  (mode_change),
    .tick (step_raw)
  );

  // A pending effect load wins over the step that would land on the same edge.
  assign tick = step_raw & ~mode_change;

  always_ff @(posedge clk) begin
    if (!reset) begin
      led  <= 8'h00;
      mode <= EFF_OFF;
      dir  <= DIR_RIGHT;
    end else if (mode_change) begin
      mode <= sw_s[2:0];
      led  <= init_pattern(sw_s[2:0]);
      dir  <= DIR_RIGHT;
    end else if (tick) begin
      case (mode)
        EFF_RUN_RIGHT: led <= (led == 8'h01) ? 8'h80 : (led >> 1);
        EFF_RUN_LEFT:  led <= (led == 8'h80) ? 8'h01 : (led << 1);
        EFF_FILL:      led <= (led == 8'hFF) ? 8'h00 : {1'b1, led[7:1]};
        EFF_PING_PONG: begin
          // Direction flips on the edge that lands on an end position.
          if (dir == DIR_RIGHT) begin
            led <= led >> 1;
            if (led == 8'h02) dir <= DIR_LEFT;
          end else begin
            led <= led << 1;
            if (led == 8'h40) dir <= DIR_RIGHT;
          end
        end
        EFF_BLINK:     led <= ~led;
        EFF_ALTERNATE: led <= ~led;
        default:       led <= 8'h00;
      endcase
    end
  end

endmodule
